// File: rtl/usb_ahb_pkg.sv
// Shared constants, address-phase payload and helpers for the USB endpoint AHB-Lite initiator.
package usb_ahb_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 7;

  localparam logic [ADDR_W-1:0] ADDR_DATA     = 7'd0;
  localparam logic [ADDR_W-1:0] ADDR_RX_READY = 7'd64;
  localparam logic [ADDR_W-1:0] ADDR_RX_ERR   = 7'd66;
  localparam logic [ADDR_W-1:0] ADDR_TX_SIZE  = 7'd72;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;

  localparam logic [1:0] HSIZE_BYTE = 2'd0;
  localparam logic [1:0] HSIZE_HALF = 2'd1;
  localparam logic [1:0] HSIZE_WORD = 2'd2;

  typedef enum logic [3:0] {
    IDLE,
    POLL_A,
    POLL_D,
    SIZE_A,
    SIZE_D,
    DATA_A,
    DATA_D,
    ERR_WAIT,
    FINISH
  } state_t;

  // Signals presented during an address phase; all zero when no transfer is issued.
  typedef struct packed {
    logic              hsel;
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic [1:0]        hsize;
    logic              hwrite;
  } ahb_addr_t;

  // Largest beat that fits in the bytes still to move.
  function automatic logic [1:0] beat_hsize(input logic [CNT_W-1:0] rem);
    if (rem >= 7'd4)      return HSIZE_WORD;
    else if (rem >= 7'd2) return HSIZE_HALF;
    else                  return HSIZE_BYTE;
  endfunction

  function automatic logic [2:0] hsize_bytes(input logic [1:0] hs);
    case (hs)
      HSIZE_BYTE: return 3'd1;
      HSIZE_HALF: return 3'd2;
      default:    return 3'd4;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] lane_mask(input logic [1:0] hs);
    case (hs)
      HSIZE_BYTE: return 32'h0000_00FF;
      HSIZE_HALF: return 32'h0000_FFFF;
      default:    return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/usb_ep_ahb_master.sv
// AHB-Lite initiator that drains RX packets from, or loads TX packets into, the USB endpoint buffer.
module usb_ep_ahb_master
  import usb_ahb_pkg::*;
#(
  parameter int unsigned POLL_MAX = 255
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              dir,
  input  logic [CNT_W-1:0]  byte_count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [2:0]        rd_bytes,
  output logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic              hsel,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic [1:0]        hsize,
  output logic              hwrite,
  output logic [DATA_W-1:0] hwdata,
  output logic [2:0]        hburst,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready,
  input  logic              hresp
);

  localparam int unsigned POLL_W = 8;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   rem, rem_nxt;
  logic [POLL_W-1:0]  poll_cnt, poll_cnt_nxt;
  logic               dir_q, dir_nxt;
  logic [CNT_W-1:0]   size_q, size_nxt;
  ahb_addr_t          addr_q, addr_nxt;
  logic               busy_nxt, done_nxt, err_nxt, wr_req_nxt;
  logic [DATA_W-1:0]  wdata_q;
  logic               wdata_held;
  logic [1:0]         beat;
  logic               bus_err;

  assign beat    = beat_hsize(rem);
  assign bus_err = hresp & ~hready;

  // State and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      rem      <= '0;
      poll_cnt <= '0;
      dir_q    <= 1'b0;
      size_q   <= '0;
      addr_q   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      wr_req   <= 1'b0;
    end else begin
      state    <= state_nxt;
      rem      <= rem_nxt;
      poll_cnt <= poll_cnt_nxt;
      dir_q    <= dir_nxt;
      size_q   <= size_nxt;
      addr_q   <= addr_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
      wr_req   <= wr_req_nxt;
    end
  end

  // Next state, counters, and the outputs to present in the coming cycle.
  always_comb begin
    state_nxt    = state;
    rem_nxt      = rem;
    poll_cnt_nxt = poll_cnt;
    dir_nxt      = dir_q;
    size_nxt     = size_q;
    err_nxt      = 1'b0;
    addr_nxt     = '0;

    case (state)
      IDLE, FINISH: begin
        state_nxt = IDLE;
        if (start) begin
          dir_nxt      = dir;
          size_nxt     = byte_count;
          rem_nxt      = byte_count;
          poll_cnt_nxt = '0;
          if (byte_count == '0) state_nxt = FINISH;
          else if (dir)         state_nxt = SIZE_A;
          else                  state_nxt = POLL_A;
        end
      end
      POLL_A: state_nxt = POLL_D;
      POLL_D: begin
        if (bus_err) begin
          state_nxt = ERR_WAIT;
        end else if (hready) begin
          if (hrdata[7:0] == 8'd1) begin
            state_nxt = DATA_A;
          end else if (poll_cnt == POLL_W'(POLL_MAX - 1)) begin
            state_nxt = FINISH;
            err_nxt   = 1'b1;
          end else begin
            poll_cnt_nxt = poll_cnt + 1'b1;
            state_nxt    = POLL_A;
          end
        end
      end
      SIZE_A: state_nxt = SIZE_D;
      SIZE_D: begin
        if (bus_err)     state_nxt = ERR_WAIT;
        else if (hready) state_nxt = DATA_A;
      end
      DATA_A: state_nxt = DATA_D;
      DATA_D: begin
        if (bus_err) begin
          state_nxt = ERR_WAIT;
        end else if (hready) begin
          rem_nxt   = rem - CNT_W'(hsize_bytes(beat));
          state_nxt = (rem_nxt == '0) ? FINISH : DATA_A;
        end
      end
      ERR_WAIT: begin
        if (hready) begin
          state_nxt = FINISH;
          err_nxt   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    case (state_nxt)
      POLL_A: begin
        addr_nxt.hsel   = 1'b1;
        addr_nxt.haddr  = ADDR_RX_READY;
        addr_nxt.htrans = HTRANS_NONSEQ;
        addr_nxt.hsize  = HSIZE_BYTE;
        addr_nxt.hwrite = 1'b0;
      end
      SIZE_A: begin
        addr_nxt.hsel   = 1'b1;
        addr_nxt.haddr  = ADDR_TX_SIZE;
        addr_nxt.htrans = HTRANS_NONSEQ;
        addr_nxt.hsize  = HSIZE_BYTE;
        addr_nxt.hwrite = 1'b1;
      end
      DATA_A: begin
        addr_nxt.hsel   = 1'b1;
        addr_nxt.haddr  = ADDR_DATA;
        addr_nxt.htrans = HTRANS_NONSEQ;
        addr_nxt.hsize  = beat_hsize(rem_nxt);
        addr_nxt.hwrite = dir_nxt;
      end
      default: addr_nxt = '0;
    endcase

    busy_nxt   = !(state_nxt inside {IDLE, FINISH});
    done_nxt   = (state_nxt == FINISH);
    wr_req_nxt = (state_nxt == DATA_A) && dir_nxt;
  end

  // TX word arrives the cycle after wr_req; hold it for the rest of a stretched data phase.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wdata_q    <= '0;
      wdata_held <= 1'b0;
    end else if (state == DATA_D) begin
      if (!wdata_held) begin
        wdata_q    <= wr_data;
        wdata_held <= 1'b1;
      end
    end else begin
      wdata_held <= 1'b0;
    end
  end

  assign hsel   = addr_q.hsel;
  assign haddr  = addr_q.haddr;
  assign htrans = addr_q.htrans;
  assign hsize  = addr_q.hsize;
  assign hwrite = addr_q.hwrite;
  assign hburst = 3'b000;

  // Read data is forwarded in the completing data-phase cycle.
  assign rd_valid = (state == DATA_D) && !dir_q && hready;
  assign rd_bytes = rd_valid ? hsize_bytes(beat) : 3'd0;
  assign rd_data  = rd_valid ? (hrdata & lane_mask(beat)) : '0;

  always_comb begin
    hwdata = '0;
    if (state == SIZE_D)              hwdata = DATA_W'(size_q);
    else if (state == DATA_D && dir_q) hwdata = wdata_held ? wdata_q : wr_data;
  end

endmodule
